// File: rtl/puf_pkg.sv
// Shared widths, sweep state encoding and result payload for the PUF challenge sequencer.
package puf_pkg;

   localparam int unsigned CHALL_W = 8;
   localparam int unsigned RESP_W  = 8;
   localparam int unsigned ONES_W  = 16;
   localparam int unsigned POP_W   = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_SETTLE,
      S_WAIT,
      S_EMIT,
      S_NEXT
   } sweep_state_t;

   // One harvested challenge/response pair as held on the output stream
   typedef struct packed {
      logic [CHALL_W-1:0] chall;
      logic [RESP_W-1:0]  resp;
      logic               timeout;
   } sweep_result_t;

endpackage

// File: rtl/puf_popcount.sv
// Combinational ones-count of one PUF response.
module puf_popcount
   import puf_pkg::*;
(
   input  logic [RESP_W-1:0] data,
   output logic [POP_W-1:0]  count_c
);

   // Sum the set bits of the response
   always_comb begin
      count_c = '0;
      for (int unsigned i = 0; i < RESP_W; i++) begin
         count_c = count_c + POP_W'(data[i]);
      end
   end

endmodule

// File: rtl/puf_sweep_ctrl.sv
// Sweeps an inclusive challenge range through a PUF, harvesting each response
// onto a valid/ready stream and accumulating the total ones-count of the sweep.
module puf_sweep_ctrl
   import puf_pkg::*;
#(
   parameter int unsigned RST_CYCLES = 1,
   parameter int unsigned TIMEOUT    = 1024
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [CHALL_W-1:0] chall_first,
   input  logic [CHALL_W-1:0] chall_last,
   output logic               puf_en,
   output logic               puf_rst,
   output logic [CHALL_W-1:0] puf_chall,
   input  logic [RESP_W-1:0]  puf_response,
   input  logic               puf_ready,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [CHALL_W-1:0] out_chall,
   output logic [RESP_W-1:0]  out_resp,
   output logic               out_timeout,
   output logic               busy,
   output logic               done,
   output logic               range_err,
   output logic [ONES_W-1:0]  ones_total
);

   localparam int unsigned RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam int unsigned WC_W = $clog2(TIMEOUT);

   sweep_state_t       state;
   sweep_state_t       next_state;
   logic [RC_W-1:0]    rst_cnt;
   logic [RC_W-1:0]    rst_cnt_nxt;
   logic [WC_W-1:0]    wait_cnt;
   logic [WC_W-1:0]    wait_cnt_nxt;
   logic [CHALL_W-1:0] cur;
   logic [CHALL_W-1:0] last_chall;
   sweep_result_t      res_q;
   logic [POP_W-1:0]   resp_ones;

   logic               go_sweep;
   logic               bad_range;
   logic               capture;
   logic               cap_timeout;
   logic               accept;
   logic               finish;
   logic               advance;

   assign puf_chall   = cur;
   assign out_chall   = res_q.chall;
   assign out_resp    = res_q.resp;
   assign out_timeout = res_q.timeout;

   puf_popcount u_popcount (
      .data    (res_q.resp),
      .count_c (resp_ones)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic and per-cycle datapath strobes
   always_comb begin
      next_state   = state;
      rst_cnt_nxt  = rst_cnt;
      wait_cnt_nxt = wait_cnt;
      go_sweep     = 1'b0;
      bad_range    = 1'b0;
      capture      = 1'b0;
      cap_timeout  = 1'b0;
      accept       = 1'b0;
      finish       = 1'b0;
      advance      = 1'b0;

      unique case (state)
         S_IDLE: begin
            if (start) begin
               if (chall_first <= chall_last) begin
                  go_sweep    = 1'b1;
                  rst_cnt_nxt = '0;
                  next_state  = S_ARM;
               end else begin
                  bad_range = 1'b1;
               end
            end
         end
         S_ARM: begin
            if (rst_cnt == RC_W'(RST_CYCLES - 1)) begin
               next_state = S_SETTLE;
            end else begin
               rst_cnt_nxt = rst_cnt + RC_W'(1);
            end
         end
         S_SETTLE: begin
            // A ready level left over from the previous challenge is ignored here
            wait_cnt_nxt = '0;
            next_state   = S_WAIT;
         end
         S_WAIT: begin
            if (puf_ready) begin
               capture    = 1'b1;
               next_state = S_EMIT;
            end else if (wait_cnt == WC_W'(TIMEOUT - 1)) begin
               capture     = 1'b1;
               cap_timeout = 1'b1;
               next_state  = S_EMIT;
            end else begin
               wait_cnt_nxt = wait_cnt + WC_W'(1);
            end
         end
         S_EMIT: begin
            if (out_ready) begin
               accept     = 1'b1;
               next_state = S_NEXT;
            end
         end
         S_NEXT: begin
            // Compare before incrementing so a range ending at the top value never wraps
            if (cur == last_chall) begin
               finish     = 1'b1;
               next_state = S_IDLE;
            end else begin
               advance     = 1'b1;
               rst_cnt_nxt = '0;
               next_state  = S_ARM;
            end
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase

      // Abort outranks every transition once a sweep is under way
      if (abort && (state != S_IDLE)) begin
         next_state = S_IDLE;
         capture    = 1'b0;
         accept     = 1'b0;
         finish     = 1'b0;
         advance    = 1'b0;
      end
   end

   // Counters, sweep bounds, held result and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         rst_cnt    <= '0;
         wait_cnt   <= '0;
         cur        <= '0;
         last_chall <= '0;
         res_q      <= '0;
         ones_total <= '0;
         puf_en     <= 1'b0;
         puf_rst    <= 1'b1;
         busy       <= 1'b0;
         out_valid  <= 1'b0;
         done       <= 1'b0;
         range_err  <= 1'b0;
      end else begin
         rst_cnt   <= rst_cnt_nxt;
         wait_cnt  <= wait_cnt_nxt;
         puf_en    <= (next_state != S_IDLE);
         busy      <= (next_state != S_IDLE);
         puf_rst   <= (next_state == S_IDLE) || (next_state == S_ARM);
         out_valid <= (next_state == S_EMIT);
         done      <= finish;
         range_err <= bad_range;

         if (go_sweep) begin
            cur        <= chall_first;
            last_chall <= chall_last;
         end else if (advance) begin
            cur <= cur + CHALL_W'(1);
         end

         if (capture) begin
            res_q.chall   <= cur;
            res_q.resp    <= cap_timeout ? '0 : puf_response;
            res_q.timeout <= cap_timeout;
         end

         if (go_sweep) begin
            ones_total <= '0;
         end else if (accept) begin
            ones_total <= ones_total + ONES_W'(resp_ones);
         end
      end
   end

endmodule

// File: tb/tb_puf_sweep_ctrl.sv
// Self-checking bench for puf_sweep_ctrl: behavioural PUF, transaction scoreboard
// and a per-cycle compare process, plus directed sweeps with literal expectations.
module tb_puf_sweep_ctrl;
   import puf_pkg::*;

   localparam int unsigned RST_CYCLES = 2;
   localparam int unsigned TIMEOUT    = 16;
   localparam int          LAT        = 5;

   typedef struct {
      logic [7:0] chall;
      logic [7:0] resp;
      logic       to;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] chall_first = 8'd0;
   logic [7:0] chall_last = 8'd0;
   logic       puf_en;
   logic       puf_rst;
   logic [7:0] puf_chall;
   logic [7:0] puf_response = 8'd0;
   logic       puf_ready = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] out_chall;
   logic [7:0] out_resp;
   logic       out_timeout;
   logic       busy;
   logic       done;
   logic       range_err;
   logic [15:0] ones_total;

   int   n_checks = 0;
   int   n_pass = 0;
   exp_t q[$];
   bit   exp_busy = 1'b0;
   bit   rerr_due = 1'b0;
   int   sum = 0;
   int   tail = 0;
   int   done_seen = 0;
   int   n_results = 0;
   int   lat = 0;
   int   rst_run = 0;
   int   to_lat = 0;
   int   cyc = 0;
   bit   prev_valid = 1'b0;
   bit   just_hs = 1'b0;
   bit   bp_mode = 1'b0;
   bit   stale_mode = 1'b0;
   int   to_chall = 300;
   int   rel_cnt = 0;

   puf_sweep_ctrl #(
      .RST_CYCLES (RST_CYCLES),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .abort        (abort),
      .chall_first  (chall_first),
      .chall_last   (chall_last),
      .puf_en       (puf_en),
      .puf_rst      (puf_rst),
      .puf_chall    (puf_chall),
      .puf_response (puf_response),
      .puf_ready    (puf_ready),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_chall    (out_chall),
      .out_resp     (out_resp),
      .out_timeout  (out_timeout),
      .busy         (busy),
      .done         (done),
      .range_err    (range_err),
      .ones_total   (ones_total)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Behavioural PUF: response = challenge ^ A5, ready LAT cycles after reset release.
   // Stale mode keeps the previous ready/response through reset and one cycle past release.
   always @(negedge clk) begin
      if (puf_rst) begin
         rel_cnt = 0;
         if (!stale_mode) puf_ready = 1'b0;
      end else begin
         rel_cnt++;
         if (stale_mode && rel_cnt == 2) puf_ready = 1'b0;
         if (rel_cnt >= LAT && int'(puf_chall) != to_chall) begin
            puf_ready    = 1'b1;
            puf_response = puf_chall ^ 8'hA5;
         end
      end
   end

   // Per-cycle compare against the scoreboard and sweep-level expectations
   always @(negedge clk) begin
      exp_t h;
      bit   exp_done_now;
      exp_done_now = 1'b0;
      if (tail > 0) begin
         tail--;
         if (tail == 0) begin
            exp_done_now = 1'b1;
            exp_busy     = 1'b0;
         end
      end
      chk("busy", busy, exp_busy);
      chk("puf_en", puf_en, exp_busy);
      chk("done", done, exp_done_now);
      if (done) done_seen++;
      chk("range_err", range_err, rerr_due);
      rerr_due = 1'b0;
      chk("ones_total", ones_total, sum);
      if (!exp_busy) begin
         chk("idle_puf_rst", puf_rst, 1);
         chk("idle_out_valid", out_valid, 0);
      end
      if (exp_busy && q.size() > 0 && !just_hs) chk("puf_chall", puf_chall, q[0].chall);
      just_hs = 1'b0;

      if (exp_busy && puf_rst) rst_run++;
      else if (rst_run != 0) begin
         chk("rst_width", rst_run, RST_CYCLES);
         rst_run = 0;
      end

      if (exp_busy) begin
         if (puf_rst) lat = 0;
         else if (!out_valid) lat++;
      end

      if (out_valid) begin
         chk("valid_puf_rst", puf_rst, 0);
         if (q.size() == 0) chk("unexpected_result", out_valid, 0);
         else begin
            h = q[0];
            chk("out_chall", out_chall, h.chall);
            chk("out_resp", out_resp, h.resp);
            chk("out_timeout", out_timeout, h.to);
            if (!prev_valid) begin
               chk("latency", lat, h.to ? TIMEOUT + 1 : LAT);
               if (h.to) to_lat = lat;
            end
         end
      end
      prev_valid = out_valid;

      cyc++;
      out_ready = bp_mode ? (cyc % 3 == 0) : 1'b1;
      if (out_valid && out_ready && q.size() > 0) begin
         h = q.pop_front();
         sum += $countones(h.resp);
         n_results++;
         just_hs = 1'b1;
         if (q.size() == 0) tail = 2;
      end
   end

   task automatic issue_start(input logic [7:0] f, input logic [7:0] l, input bit with_abort);
      exp_t e;
      @(negedge clk); #1;
      start = 1'b1;
      abort = with_abort;
      chall_first = f;
      chall_last = l;
      if (f <= l) begin
         q.delete();
         sum = 0;
         exp_busy = 1'b1;
         for (int c = int'(f); c <= int'(l); c++) begin
            e.chall = 8'(c);
            e.to    = (c == to_chall);
            e.resp  = e.to ? 8'h00 : (8'(c) ^ 8'hA5);
            q.push_back(e);
         end
      end else begin
         rerr_due = 1'b1;
      end
      @(negedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
   endtask

   task automatic finish_sweep(input int d0, input int r0, input int n_exp, input int budget);
      for (int i = 0; i < budget && done_seen == d0; i++) @(negedge clk);
      chk("sweep_done", done_seen - d0, 1);
      chk("sweep_count", n_results - r0, n_exp);
      #1;
   endtask

   task automatic sweep(input logic [7:0] f, input logic [7:0] l, input int budget);
      int d0;
      int r0;
      d0 = done_seen;
      r0 = n_results;
      issue_start(f, l, 1'b0);
      finish_sweep(d0, r0, int'(l) - int'(f) + 1, budget);
   endtask

   task automatic reach_wait_of_40();
      for (int i = 0; i < 400 && !(puf_chall == 8'd40 && busy && !puf_rst && !out_valid); i++)
         @(negedge clk);
      chk("reach_chall_40", puf_chall, 40);
      @(negedge clk); #1;
   endtask

   initial begin
      int d0;
      int r0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_puf_en", puf_en, 0);
      chk("rst_puf_rst", puf_rst, 1);
      chk("rst_puf_chall", puf_chall, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_chall", out_chall, 0);
      chk("rst_out_resp", out_resp, 0);
      chk("rst_out_timeout", out_timeout, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_range_err", range_err, 0);
      chk("rst_ones_total", ones_total, 0);
      rst = 1'b0;

      // Full range 1..255; A5 xor permutes bytes, so total = 256*4 - popcount(A5) = 1020
      sweep(8'd1, 8'd255, 255 * 12);
      chk("full_ones_total", ones_total, 1020);

      // Backpressure 1-of-3 with a start pulse that must be ignored mid-sweep
      bp_mode = 1'b1;
      d0 = done_seen;
      r0 = n_results;
      issue_start(8'd20, 8'd30, 1'b0);
      repeat (12) @(negedge clk);
      #1;
      start = 1'b1;
      chall_first = 8'd0;
      chall_last = 8'd0;
      @(negedge clk); #1;
      start = 1'b0;
      finish_sweep(d0, r0, 11, 400);
      bp_mode = 1'b0;

      // Stale ready from the previous challenge must not be captured
      stale_mode = 1'b1;
      puf_ready = 1'b1;
      puf_response = 8'hEE;
      sweep(8'd50, 8'd53, 100);
      chk("stale_ones_total", ones_total, 14);
      stale_mode = 1'b0;

      // Challenge 7 never answers: timeout after 16 wait cycles, sweep continues with 8
      to_chall = 7;
      sweep(8'd5, 8'd9, 200);
      chk("timeout_latency", to_lat, 17);
      to_chall = 300;

      // Single challenge at the top of the range: no wrap
      sweep(8'd255, 8'd255, 40);
      chk("top_ones_total", ones_total, 4);
      repeat (3) @(negedge clk);
      #1;
      chk("top_puf_chall_held", puf_chall, 255);
      chk("top_busy", busy, 0);

      // Reversed range
      issue_start(8'd9, 8'd3, 1'b0);
      chk("rerr_pulse", range_err, 1);
      chk("rerr_busy", busy, 0);
      @(negedge clk); #1;
      chk("rerr_one_cycle", range_err, 0);

      // Abort during WAIT of challenge 40 (start issued together with abort must win)
      issue_start(8'd38, 8'd45, 1'b1);
      reach_wait_of_40();
      abort = 1'b1;
      exp_busy = 1'b0;
      q.delete();
      @(negedge clk); #1;
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_puf_rst", puf_rst, 1);
      chk("abort_done", done, 0);
      chk("abort_ones_total", ones_total, 5);
      repeat (3) @(negedge clk);

      // Same with synchronous reset
      issue_start(8'd38, 8'd45, 1'b0);
      reach_wait_of_40();
      rst = 1'b1;
      exp_busy = 1'b0;
      q.delete();
      sum = 0;
      @(negedge clk); #1;
      chk("mrst_puf_en", puf_en, 0);
      chk("mrst_puf_rst", puf_rst, 1);
      chk("mrst_puf_chall", puf_chall, 0);
      chk("mrst_out_valid", out_valid, 0);
      chk("mrst_out_chall", out_chall, 0);
      chk("mrst_out_resp", out_resp, 0);
      chk("mrst_out_timeout", out_timeout, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_done", done, 0);
      chk("mrst_ones_total", ones_total, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/puf_sweep_ctrl.md
# puf_sweep_ctrl

Challenge sequencer that sits directly upstream of `top_PUF`: it sweeps an inclusive challenge range, and for each challenge it drives `chall_in`, pulses the PUF reset, and waits for `ready`. It then captures `response` and presents it on a valid/ready output stream tagged with its challenge. Hardware replaces the bench loop, so full challenge–response tables can be harvested on silicon. It also accumulates a running ones-count for uniformity metrics.

## Interface
Parameters:
- `RST_CYCLES`, 1: cycles `puf_rst` is held high per challenge (≥1).
- `TIMEOUT`, 1024: max cycles waited for `puf_ready` before flagging a timeout (≥2).

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a sweep; honoured only in IDLE.
- `abort`  in  1  terminates the sweep in any non-IDLE state.
- `chall_first`  in  8  first challenge; sampled with `start`.
- `chall_last`  in  8  last challenge, inclusive; sampled with `start`.
- `puf_en`  out  1  PUF enable.
- `puf_rst`  out  1  PUF reset.
- `puf_chall`  out  8  challenge to the PUF.
- `puf_response`  in  8  PUF response.
- `puf_ready`  in  1  PUF response valid (level).
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts.
- `out_chall`  out  8  challenge of the held result.
- `out_resp`  out  8  captured response; 0 on timeout.
- `out_timeout`  out  1  result is a timeout.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse after the last result is accepted.
- `range_err`  out  1  one-cycle pulse when `start` sees `chall_first > chall_last`.
- `ones_total`  out  16  sum of popcount(`out_resp`) over accepted results this sweep.

## Operation
States are IDLE, ARM, SETTLE, WAIT, EMIT, NEXT.

- **IDLE**
  - With `start=1` and `chall_first ≤ chall_last`: latch `cur=chall_first` and `last=chall_last`, clear `ones_total`, go to ARM.
  - With `start=1` and `chall_first > chall_last`: pulse `range_err`, stay in IDLE.
- **ARM**
  - `puf_chall=cur`, `puf_rst=1` for exactly `RST_CYCLES` cycles, then go to SETTLE.
- **SETTLE**
  - One cycle with `puf_rst=0` and `puf_ready` ignored. This masks a stale `ready`.
  - Clear the wait counter, go to WAIT.
- **WAIT**
  - If `puf_ready=1`: capture `puf_response` into `out_resp`, set `out_timeout=0`, go to EMIT.
  - Otherwise increment the wait counter. When it reaches `TIMEOUT-1` without `ready`: `out_resp=0`, `out_timeout=1`, go to EMIT.
- **EMIT**
  - `out_valid=1`. `out_chall`, `out_resp` and `out_timeout` are held stable until `out_ready`.
  - On handshake: add popcount(`out_resp`) to `ones_total`, go to NEXT.
- **NEXT**
  - If `cur==last`: pulse `done`, go to IDLE.
  - Otherwise `cur<=cur+1`, go to ARM.
  - The comparison is made before the increment, so `last=255` never wraps to 0.

Other rules:
- `puf_en=1` in all states except IDLE.
- `puf_chall` holds `cur` outside IDLE and holds its last value in IDLE.
- `abort` has priority over all transitions. It goes to IDLE on the next edge, drops `out_valid`, and gives no `done`. `ones_total` keeps its partial value.
- `start` is ignored while `busy`.
- `start` and `abort` asserted together in IDLE: `start` wins.

## Timing
- Reset values: `puf_en=0`, `puf_rst=1`, `puf_chall=0`, `out_valid=0`, `out_chall=0`, `out_resp=0`, `out_timeout=0`, `busy=0`, `done=0`, `range_err=0`, `ones_total=0`, state IDLE.
- `puf_rst` is 1 in IDLE, so the PUF is parked in reset.
- Reset mid-sweep gives the same state as power-on reset, with no `done`.
- `start` at edge N gives ARM at N+1. `puf_rst` is high for cycles N+1 … N+RST_CYCLES.
- SETTLE is at N+RST_CYCLES+1. The earliest WAIT sample is at N+RST_CYCLES+2.
- With `ready` present at the first WAIT sample, `out_valid` rises one cycle later.
- Per-challenge overhead, excluding PUF latency: RST_CYCLES + 4 cycles (ARM, SETTLE, 1 WAIT sample, EMIT, NEXT), assuming `out_ready` is held high.
- `ones_total` updates the cycle after the handshake.
- Width: 256 × 8 = 2048 fits in 16 bits, so `ones_total` never saturates.

## Structure
- Package `puf_pkg`:
  - `CHALL_W=8`, `RESP_W=8`, `ONES_W=16`.
  - State enum `sweep_state_t`.
  - Shared with `top_PUF` wrappers.
- Sub-module `puf_popcount`: combinational 8-bit popcount returning 4 bits.
- Wait counter: `$clog2(TIMEOUT)` bits.

## Test plan
- **Full range:** `chall_first=1`, `chall_last=255`, `out_ready=1`, behavioural PUF with `response=chall^8'hA5` and ready 5 cycles after reset release.
  - 255 results in order 1…255 with `out_resp` matching, then one `done`.
  - `ones_total` equals the sum of popcount(`chall^A5`) over 1…255.
- **Stale ready:** model keeps `ready=1` through reset release and lowers it 2 cycles later.
  - SETTLE masking must prevent capture of the previous response.
- **Backpressure:** `out_ready` toggles 1-of-3.
  - Output fields stay stable while stalled.
  - No challenge is skipped or duplicated.
  - `puf_rst` is not re-pulsed until after the handshake.
- **Timeout:** `TIMEOUT=16`, PUF never ready for challenge 7.
  - Challenge 7 is emitted with `out_timeout=1` and `out_resp=0` after exactly 16 WAIT cycles.
  - The sweep continues with challenge 8.
- **Boundaries:**
  - `first=last=255`: one result, `done`, no wrap.
  - `first=9`, `last=3`: `range_err` pulse, `busy` stays 0.
- **Abort/reset:**
  - `abort` during WAIT of challenge 40: IDLE next cycle, `out_valid=0`, no `done`, `puf_rst=1`.
  - Same test with `rst` instead of `abort`: all outputs return to their reset values.
